// File: rtl/risc_pkg.sv
// Shared types and default parameters for the RISC core fetch/retire sequencer.
package risc_pkg;

  localparam int XLEN_DEFAULT      = 32;
  localparam int PC_RESET_DEFAULT  = 0;
  localparam int RES_DEPTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    BOOT,
    FETCH_REQ,
    FETCH_WAIT,
    EXECUTE,
    COMMIT,
    HALTED
  } seq_state_e;

endpackage

// File: rtl/risc_core_sequencer_if.sv
// Bundle of fetch, execute-completion, halt and result-stream signals around the sequencer.
interface risc_core_sequencer_if #(
  parameter int XLEN = risc_pkg::XLEN_DEFAULT
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic [31:0]     instr;
  logic            instr_valid;
  logic            exec_done;
  logic            exec_halt;
  logic            exec_branch;
  logic [XLEN-1:0] exec_target;
  logic            exec_we;
  logic [XLEN-1:0] exec_result;
  logic            resume;
  logic            halted;
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] res_data;
  logic [XLEN-1:0] pc;

  // Core side
  modport master (
    output imem_req_valid, imem_addr, instr, instr_valid, halted, res_valid, res_data, pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, exec_done, exec_halt, exec_branch,
           exec_target, exec_we, exec_result, resume, res_ready
  );

  // Memory / execute / display side
  modport slave (
    input  imem_req_valid, imem_addr, instr, instr_valid, halted, res_valid, res_data, pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, exec_done, exec_halt, exec_branch,
           exec_target, exec_we, exec_result, resume, res_ready
  );
endinterface

// File: rtl/risc_result_fifo.sv
// First-word-fall-through result buffer; accepts a push while full when a pop happens the same cycle.
module risc_result_fifo
  import risc_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int RES_DEPTH = RES_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_data_i,
  output logic            can_push_o,
  input  logic            pop_ready_i,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o
);
  localparam int AW = $clog2(RES_DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] mem [RES_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full;
  logic            pop;
  logic            push_fire;

  assign full       = (count_q == CW'(RES_DEPTH));
  assign valid_o    = (count_q != '0);
  assign pop        = valid_o & pop_ready_i;
  assign can_push_o = ~full | pop;
  assign push_fire  = push_i & can_push_o;
  // Empty buffer shows zero rather than stale storage.
  assign data_o     = valid_o ? mem[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)       rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_fire, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/risc_core_sequencer.sv
// Fetch / execute-wait / retire sequencer with PC tracking, halt control and a result FIFO.
module risc_core_sequencer
  import risc_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] PC_RESET  = XLEN'(PC_RESET_DEFAULT),
  parameter int              RES_DEPTH = RES_DEPTH_DEFAULT
) (
  input logic                   clk,
  input logic                   rst,
  risc_core_sequencer_if.master bus
);
  seq_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            c_halt_q, c_halt_d;
  logic            c_branch_q, c_branch_d;
  logic [XLEN-1:0] c_target_q, c_target_d;
  logic [XLEN-1:0] c_result_q, c_result_d;

  logic            req_valid;
  logic            halted;
  logic            fifo_push;
  logic [XLEN-1:0] fifo_data;
  logic            fifo_can_push;
  logic            res_valid;
  logic [XLEN-1:0] res_data;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    c_halt_d      = c_halt_q;
    c_branch_d    = c_branch_q;
    c_target_d    = c_target_q;
    c_result_d    = c_result_q;
    req_valid     = 1'b0;
    halted        = 1'b0;
    fifo_push     = 1'b0;
    fifo_data     = bus.exec_result;

    unique case (state_q)
      BOOT: state_d = FETCH_REQ;

      FETCH_REQ: begin
        req_valid = 1'b1;
        if (bus.imem_req_ready) state_d = FETCH_WAIT;
      end

      FETCH_WAIT: begin
        if (bus.imem_rsp_valid) begin
          instr_d       = bus.imem_rsp_data;
          instr_valid_d = 1'b1;
          state_d       = EXECUTE;
        end
      end

      EXECUTE: begin
        if (bus.exec_done) begin
          // A result with nowhere to go parks the whole bundle until the FIFO drains.
          if (bus.exec_we && !fifo_can_push) begin
            c_halt_d   = bus.exec_halt;
            c_branch_d = bus.exec_branch;
            c_target_d = bus.exec_target;
            c_result_d = bus.exec_result;
            state_d    = COMMIT;
          end else begin
            fifo_push = bus.exec_we;
            pc_d      = bus.exec_branch ? bus.exec_target : pc_q + XLEN'(1);
            state_d   = bus.exec_halt ? HALTED : FETCH_REQ;
          end
        end
      end

      COMMIT: begin
        fifo_data = c_result_q;
        if (fifo_can_push) begin
          fifo_push = 1'b1;
          pc_d      = c_branch_q ? c_target_q : pc_q + XLEN'(1);
          state_d   = c_halt_q ? HALTED : FETCH_REQ;
        end
      end

      HALTED: begin
        halted = 1'b1;
        if (bus.resume) state_d = FETCH_REQ;
      end

      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      pc_q          <= PC_RESET;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      c_halt_q      <= 1'b0;
      c_branch_q    <= 1'b0;
      c_target_q    <= '0;
      c_result_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      c_halt_q      <= c_halt_d;
      c_branch_q    <= c_branch_d;
      c_target_q    <= c_target_d;
      c_result_q    <= c_result_d;
    end
  end

  risc_result_fifo #(
    .XLEN      (XLEN),
    .RES_DEPTH (RES_DEPTH)
  ) u_result_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (fifo_data),
    .can_push_o  (fifo_can_push),
    .pop_ready_i (bus.res_ready),
    .valid_o     (res_valid),
    .data_o      (res_data)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.instr          = instr_q;
  assign bus.instr_valid    = instr_valid_q;
  assign bus.halted         = halted;
  assign bus.res_valid      = res_valid;
  assign bus.res_data       = res_data;
  assign bus.pc             = pc_q;

endmodule

// File: tb/tb_risc_core_sequencer.sv
// Scoreboard bench: stimulus predicts fetch addresses, instructions and results; a monitor checks them.
module tb_risc_core_sequencer;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  risc_core_sequencer_if #(.XLEN(XLEN)) bus ();

  risc_core_sequencer #(
    .XLEN      (XLEN),
    .PC_RESET  (32'h0),
    .RES_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_res_q  [$];
  logic [31:0] model_pc;
  logic [31:0] cur_instr;
  int          rr_mode = 1;   // 0 random, 1 hold low, 2 hold high

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every DUT-presented transaction is matched against the predicted queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          if (exp_addr_q.size() == 0) begin
            n_checks++;
            $display("FAIL fetch_unexpected: got addr 0x%0h required no fetch", bus.imem_addr);
          end else begin
            logic [31:0] e;
            e = exp_addr_q.pop_front();
            chk("fetch_addr", bus.imem_addr, e);
            $display("fetch  addr=0x%08h", bus.imem_addr);
          end
        end
        if (bus.instr_valid) begin
          if (exp_instr_q.size() == 0) begin
            n_checks++;
            $display("FAIL instr_unexpected: got instr 0x%0h required no issue", bus.instr);
          end else begin
            logic [31:0] e;
            e = exp_instr_q.pop_front();
            chk("instr_issue", bus.instr, e);
            $display("issue  instr=0x%08h", bus.instr);
          end
        end
        if (bus.res_valid && bus.res_ready) begin
          if (exp_res_q.size() == 0) begin
            n_checks++;
            $display("FAIL res_unexpected: got data 0x%0h required no result", bus.res_data);
          end else begin
            logic [31:0] e;
            e = exp_res_q.pop_front();
            chk("res_data", bus.res_data, e);
            $display("result data=0x%08h", bus.res_data);
          end
        end
      end
    end
  end

  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       bus.res_ready = 1'($urandom_range(0, 1));
        1:       bus.res_ready = 1'b0;
        default: bus.res_ready = 1'b1;
      endcase
    end
  end

  task automatic wait_req();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.imem_req_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL fetch_timeout: imem_req_valid=0 after 200 cycles required 1");
    end
  endtask

  task automatic fetch(input int ready_delay, input int rsp_delay, input logic [31:0] idata);
    wait_req();
    exp_addr_q.push_back(model_pc);
    repeat (ready_delay) begin
      tick();
      chk("req_hold_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("req_hold_addr", bus.imem_addr, model_pc);
    end
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    repeat (rsp_delay) tick();
    cur_instr = idata;
    exp_instr_q.push_back(idata);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = idata;
    tick();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
  endtask

  task automatic execute(input int delay, input logic halt, input logic branch, input logic we,
                         input logic [31:0] target, input logic [31:0] result);
    repeat (delay) tick();
    chk("instr_hold", bus.instr, cur_instr);
    bus.exec_done   = 1'b1;
    bus.exec_halt   = halt;
    bus.exec_branch = branch;
    bus.exec_we     = we;
    bus.exec_target = target;
    bus.exec_result = result;
    tick();
    bus.exec_done   = 1'b0;
    bus.exec_halt   = 1'($urandom_range(0, 1));
    bus.exec_branch = 1'($urandom_range(0, 1));
    bus.exec_we     = 1'($urandom_range(0, 1));
    bus.exec_target = $urandom;
    bus.exec_result = $urandom;
    if (we) exp_res_q.push_back(result);
    model_pc = branch ? target : model_pc + 32'd1;
  endtask

  task automatic halt_release(input int quiet_cycles);
    bit ok = 1'b0;
    bit fetched = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.halted) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("halted_set", 32'(ok), 32'd1);
    repeat (quiet_cycles) begin
      tick();
      if (bus.imem_req_valid || !bus.halted) fetched = 1'b1;
    end
    chk("halt_no_fetch", 32'(fetched), 32'd0);
    chk("halt_pc", bus.pc, model_pc);
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    chk("halted_clear", 32'(bus.halted), 32'd0);
  endtask

  task automatic drain();
    rr_mode = 2;
    for (int i = 0; i < 100; i++) begin
      if (!bus.res_valid && exp_res_q.size() == 0) break;
      tick();
    end
    chk("drain_empty", 32'(exp_res_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
    chk({tag, "_addr"}, bus.imem_addr, 32'd0);
    chk({tag, "_pc"}, bus.pc, 32'd0);
    chk({tag, "_instr"}, bus.instr, 32'd0);
    chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, "_halted"}, 32'(bus.halted), 32'd0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_res_data"}, bus.res_data, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc_before;
    bit          fetched;

    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.exec_done      = 1'b0;
    bus.exec_halt      = 1'b0;
    bus.exec_branch    = 1'b0;
    bus.exec_target    = '0;
    bus.exec_we        = 1'b0;
    bus.exec_result    = '0;
    bus.resume         = 1'b0;
    model_pc           = 32'd0;
    cur_instr          = 32'd0;

    // Reset state, single BOOT cycle, stalled request stays stable.
    repeat (3) tick();
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("boot_req_valid", 32'(bus.imem_req_valid), 32'd0);
    tick();
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("first_req_addr", bus.imem_addr, 32'd0);
    repeat (5) begin
      tick();
      chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("stall_req_addr", bus.imem_addr, 32'd0);
    end

    // Three sequential retires with results 0xA, 0xB, 0xC.
    rr_mode = 2;
    for (int k = 0; k < 3; k++) begin
      fetch(0, 1, $urandom);
      chk("seq_pc_before", bus.pc, 32'(k));
      execute(1, 1'b0, 1'b0, 1'b1, $urandom, 32'hA + 32'(k));
      chk("seq_pc_after", bus.pc, model_pc);
    end

    // Branch to 0x40, then wrap from 0xFFFFFFFF to 0.
    fetch(1, 0, $urandom);
    execute(0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h1234);
    fetch(0, 0, $urandom);
    execute(2, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, $urandom);
    fetch(2, 2, $urandom);
    execute(0, 1'b0, 1'b0, 1'b1, $urandom, 32'h5555);
    chk("pc_wrap", bus.pc, 32'd0);
    fetch(0, 0, $urandom);
    execute(0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);

    // Fill the FIFO with the sink stalled; fifth result parks the core.
    drain();
    rr_mode = 1;
    for (int k = 0; k < 5; k++) begin
      fetch(0, 0, $urandom);
      pc_before = bus.pc;
      execute(0, 1'b0, 1'b0, 1'b1, $urandom, 32'h100 + 32'(k));
    end
    chk("commit_pc_hold", bus.pc, pc_before);
    fetched = 1'b0;
    repeat (6) begin
      tick();
      if (bus.imem_req_valid) fetched = 1'b1;
    end
    chk("commit_no_fetch", 32'(fetched), 32'd0);
    chk("commit_res_valid", 32'(bus.res_valid), 32'd1);
    rr_mode = 2;
    fetch(0, 0, $urandom);
    execute(0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);

    // Halt at pc=7, then resume fetches at 8.
    fetch(0, 0, $urandom);
    execute(0, 1'b0, 1'b1, 1'b0, 32'd7, $urandom);
    fetch(0, 0, $urandom);
    execute(0, 1'b1, 1'b0, 1'b1, $urandom, 32'h77);
    halt_release(20);
    fetch(0, 0, $urandom);
    chk("resume_pc", bus.pc, 32'd8);
    // Halt combined with branch still takes the target.
    execute(0, 1'b1, 1'b1, 1'b0, 32'h100, $urandom);
    halt_release(3);
    fetch(0, 0, $urandom);
    execute(0, 1'b0, 1'b0, 1'b1, $urandom, 32'hBEEF);

    // Randomised traffic against the model.
    rr_mode = 0;
    for (int k = 0; k < 40; k++) begin
      logic h;
      h = ($urandom_range(0, 9) == 0);
      fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      execute($urandom_range(0, 3), h, 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 3) != 0), $urandom, $urandom);
      if (h) halt_release(4);
    end

    // Reset in EXECUTE with two buffered results; a late response must be ignored.
    drain();
    rr_mode = 1;
    for (int k = 0; k < 2; k++) begin
      fetch(0, 0, $urandom);
      execute(0, 1'b0, 1'b0, 1'b1, $urandom, 32'h200 + 32'(k));
    end
    fetch(0, 0, $urandom);
    chk("pre_reset_res_valid", 32'(bus.res_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midexec_reset");
    exp_res_q.delete();
    exp_addr_q.delete();
    exp_instr_q.delete();
    model_pc = 32'd0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      tick();
      chk("late_rsp_instr", bus.instr, 32'd0);
    end
    bus.imem_rsp_valid = 1'b0;
    rr_mode = 2;
    fetch(0, 0, $urandom);
    execute(0, 1'b0, 1'b0, 1'b1, $urandom, 32'h3333);

    drain();
    chk("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    chk("instr_queue_empty", 32'(exp_instr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/risc_core_sequencer.md
RISC_CORE_SEQUENCER -- requirements
Module: risc_core_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC/result data width (16..64).
REQ-002 SHALL have parameter PC_RESET, default 0, meaning first fetch address.
REQ-003 SHALL have parameter RES_DEPTH, default 4, meaning result FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports imem_req_valid out 1 / imem_req_ready in 1 / imem_addr out XLEN  fetch request handshake.
REQ-007 SHALL have ports imem_rsp_valid in 1 / imem_rsp_data in 32  fetch response.
REQ-008 SHALL have ports instr out 32 / instr_valid out 1  captured instruction, 1-cycle issue strobe to decoder/control.
REQ-009 SHALL have ports exec_done in 1 / exec_halt in 1 / exec_branch in 1 / exec_target in XLEN / exec_we in 1 / exec_result in XLEN  execute completion bundle, sampled only when exec_done=1.
REQ-010 SHALL have ports resume in 1 / halted out 1  halt release pulse, halt status.
REQ-011 SHALL have ports res_valid out 1 / res_ready in 1 / res_data out XLEN  display result stream.
REQ-012 SHALL have port pc out XLEN  current PC.

Function
REQ-013 FSM states SHALL be BOOT, FETCH_REQ, FETCH_WAIT, EXECUTE, COMMIT, HALTED.
REQ-014 BOOT SHALL last exactly one cycle after reset release, all handshake outputs 0, then enter FETCH_REQ.
REQ-015 FETCH_REQ SHALL drive imem_req_valid=1, imem_addr=pc; on imem_req_ready=1 go FETCH_WAIT; valid SHALL NOT drop before ready.
REQ-016 FETCH_WAIT SHALL, on imem_rsp_valid=1, register imem_rsp_data into instr, pulse instr_valid next cycle for exactly one cycle, enter EXECUTE.
REQ-017 EXECUTE SHALL wait indefinitely for exec_done; instr SHALL hold stable throughout.
REQ-018 Retire (exec_done=1 and, if exec_we=1, FIFO has space or pops this cycle) SHALL: push exec_result when exec_we=1; pc <= exec_branch ? exec_target : pc+1 (mod 2^XLEN); next state HALTED if exec_halt else FETCH_REQ.
REQ-019 If exec_done=1, exec_we=1 and FIFO full with no simultaneous pop, SHALL latch the bundle and enter COMMIT; COMMIT retires per REQ-018 in the first cycle space exists.
REQ-020 HALTED SHALL assert halted=1, issue no fetches, and on resume=1 enter FETCH_REQ at the already-updated pc; resume outside HALTED SHALL be ignored.
REQ-021 FIFO SHALL present res_valid=1 whenever non-empty with res_data = oldest entry; pop on res_valid&res_ready; simultaneous push and pop when full SHALL be accepted with no loss.
REQ-022 FIFO contents SHALL continue draining in HALTED and COMMIT states.
REQ-023 exec_halt with exec_branch=1 SHALL still load exec_target before halting.

Reset
REQ-024 rst=0 SHALL immediately force state BOOT, pc=PC_RESET, instr=0, instr_valid=0, imem_req_valid=0, imem_addr=PC_RESET, halted=0, FIFO empty (res_valid=0, res_data=0), regardless of any in-flight fetch or execute.
REQ-025 A response arriving after reset mid-fetch SHALL be ignored unless the FSM is in FETCH_WAIT.

Structure
REQ-026 Package risc_pkg SHALL hold the FSM state enum and default XLEN/PC_RESET/RES_DEPTH constants.
REQ-027 The result buffer SHALL be a separate sub-module risc_result_fifo (params XLEN, RES_DEPTH).

Verification
REQ-028 Reset release -> BOOT 1 cycle, then imem_req_valid=1, imem_addr=0; ready held 0 for 5 cycles -> valid/addr stable.
REQ-029 Sequential retire of 3 non-branch instrs with exec_we=1, results 0xA,0xB,0xC, res_ready=1 -> pc 0,1,2,3; res_data 0xA,0xB,0xC in order.
REQ-030 Branch retire with exec_target=0x40 -> next imem_addr=0x40; pc=0xFFFFFFFF non-branch -> wraps to 0.
REQ-031 res_ready=0, 4 writes fill FIFO, 5th exec_done -> COMMIT, no fetch; raise res_ready -> 5th value pushed, fetch resumes, all 5 values output in order.
REQ-032 exec_halt at pc=7 -> halted=1, no fetch for 20 cycles; resume pulse -> imem_addr=8.
REQ-033 rst=0 mid-EXECUTE with 2 FIFO entries -> res_valid=0, pc=PC_RESET immediately; late imem_rsp_valid ignored.
